fetch: RTL and testbench

//  Front-end fetch stage: owns the PC and issues in-order word requests to the I-cache.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 39 +++
 rtl/fetch.sv | 80 ++++++++
 tb/tb_fetch.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage
package fetch_pkg;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int BPTAG_W = 16;
   typedef enum logic {RUN, HALT} state_t;
   typedef struct packed {
      logic               error;
      logic [30:0]        addr;
      logic [31:0]        insn;
      logic [BPTAG_W-1:0] bptag;
      logic               bptaken;
   } entry_t;
   typedef struct packed {
      logic [29:0]        addr;
      logic               bptaken;
      logic [BPTAG_W-1:0] bptag;
   } inflight_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with occupancy count and flush
module fetch_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
)(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           push,
   input  logic                           pop,
   input  logic                           flush,
   input  logic [WIDTH-1:0]               din,
   output logic [WIDTH-1:0]               dout,
   output logic [$clog2(DEPTH+1)-1:0]     count
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic do_push, do_pop;
   assign do_pop = pop & (count != '0);
   assign do_push = push & ((count != CW'(DEPTH)) | do_pop);
   assign dout = mem[rp];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else if (flush) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop) rp <= rp + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push && !flush) mem[wp] <= din;
endmodule

// File: rtl/fetch.sv
// fetch: PC owner issuing I-cache requests and queueing responses for decode
module fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int QDEPTH = 4
)(
   input  logic               clk,
   input  logic               rst_n,
   output logic               fetch_ic_req,
   output logic [29:0]        fetch_ic_addr,
   input  logic               ic_fetch_ready,
   input  logic               ic_fetch_valid,
   input  logic               ic_fetch_error,
   input  logic [31:0]        ic_fetch_insn,
   output logic [29:0]        fetch_bp_addr,
   input  logic               bp_fetch_taken,
   input  logic [30:0]        bp_fetch_target,
   input  logic [BPTAG_W-1:0] bp_fetch_tag,
   output logic               fetch_de_valid,
   output logic               fetch_de_error,
   output logic [30:0]        fetch_de_addr,
   output logic [31:0]        fetch_de_insn,
   output logic [BPTAG_W-1:0] fetch_de_bptag,
   output logic               fetch_de_bptaken,
   input  logic               decode_stall,
   input  logic               rob_flush,
   input  logic [30:0]        rob_flush_pc
);
   localparam int CW = $clog2(QDEPTH+1);
   state_t state, state_nx;
   logic [31:1] pc;
   logic [CW-1:0] inflight, qcount, drop;
   logic [CW:0] used;
   logic hs, resp_keep, mis_push, q_push, q_pop;
   inflight_t if_in, if_out;
   entry_t q_in, q_out;
   // in-flight requests and queued entries share one credit pool so a response always finds room
   assign used = {1'b0, inflight} + {1'b0, qcount};
   assign fetch_ic_req = rst_n & (state == RUN) & ~pc[1] & ~rob_flush & (used < (CW+1)'(QDEPTH));
   assign fetch_ic_addr = pc[31:2];
   assign fetch_bp_addr = pc[31:2];
   assign hs = fetch_ic_req & ic_fetch_ready;
   assign resp_keep = ic_fetch_valid & ~rob_flush & (drop == '0);
   assign mis_push = (state == RUN) & pc[1] & ~rob_flush & (inflight == '0) & (qcount < CW'(QDEPTH));
   assign q_push = resp_keep | mis_push;
   assign q_pop = fetch_de_valid & ~decode_stall;
   assign if_in = '{addr: pc[31:2], bptaken: bp_fetch_taken, bptag: bp_fetch_tag};
   assign q_in = mis_push ? '{error: 1'b1, addr: pc, insn: '0, bptag: '0, bptaken: 1'b0}
                          : '{error: ic_fetch_error, addr: {if_out.addr, 1'b0},
                              insn: ic_fetch_error ? '0 : ic_fetch_insn,
                              bptag: if_out.bptag, bptaken: if_out.bptaken};
   fetch_fifo #(.WIDTH($bits(inflight_t)), .DEPTH(QDEPTH)) u_inflight (
      .clk(clk), .rst_n(rst_n), .push(hs), .pop(ic_fetch_valid), .flush(1'b0),
      .din(if_in), .dout(if_out), .count(inflight)
   );
   fetch_fifo #(.WIDTH($bits(entry_t)), .DEPTH(QDEPTH)) u_queue (
      .clk(clk), .rst_n(rst_n), .push(q_push), .pop(q_pop), .flush(rob_flush),
      .din(q_in), .dout(q_out), .count(qcount)
   );
   assign fetch_de_valid = qcount != '0;
   assign fetch_de_error = fetch_de_valid & q_out.error;
   assign fetch_de_addr = fetch_de_valid ? q_out.addr : '0;
   assign fetch_de_insn = fetch_de_valid ? q_out.insn : '0;
   assign fetch_de_bptag = fetch_de_valid ? q_out.bptag : '0;
   assign fetch_de_bptaken = fetch_de_valid & q_out.bptaken;
   always_comb
      state_nx = rob_flush ? RUN : (mis_push | (resp_keep & ic_fetch_error)) ? HALT : state;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         pc <= RESET_PC[31:1];
         state <= RUN;
         drop <= '0;
      end else begin
         pc <= rob_flush ? rob_flush_pc : hs ? (bp_fetch_taken ? bp_fetch_target : pc + 31'd2) : pc;
         state <= state_nx;
         drop <= rob_flush ? inflight - CW'(ic_fetch_valid)
               : (ic_fetch_valid && drop != '0) ? drop - 1'b1 : drop;
      end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed scoreboard bench for the fetch stage with a latency-configurable cache model
module tb_fetch;
   logic clk = 0, rst_n = 0;
   logic fetch_ic_req, ic_fetch_ready, ic_fetch_valid = 0, ic_fetch_error = 0;
   logic [29:0] fetch_ic_addr, fetch_bp_addr;
   logic [31:0] ic_fetch_insn = 0;
   logic bp_fetch_taken;
   logic [30:0] bp_fetch_target;
   logic [15:0] bp_fetch_tag;
   logic fetch_de_valid, fetch_de_error, fetch_de_bptaken;
   logic [30:0] fetch_de_addr;
   logic [31:0] fetch_de_insn;
   logic [15:0] fetch_de_bptag;
   logic decode_stall = 0, rob_flush = 0;
   logic [30:0] rob_flush_pc = 0;

   fetch dut (
      .clk(clk), .rst_n(rst_n), .fetch_ic_req(fetch_ic_req), .fetch_ic_addr(fetch_ic_addr),
      .ic_fetch_ready(ic_fetch_ready), .ic_fetch_valid(ic_fetch_valid), .ic_fetch_error(ic_fetch_error),
      .ic_fetch_insn(ic_fetch_insn), .fetch_bp_addr(fetch_bp_addr), .bp_fetch_taken(bp_fetch_taken),
      .bp_fetch_target(bp_fetch_target), .bp_fetch_tag(bp_fetch_tag), .fetch_de_valid(fetch_de_valid),
      .fetch_de_error(fetch_de_error), .fetch_de_addr(fetch_de_addr), .fetch_de_insn(fetch_de_insn),
      .fetch_de_bptag(fetch_de_bptag), .fetch_de_bptaken(fetch_de_bptaken), .decode_stall(decode_stall),
      .rob_flush(rob_flush), .rob_flush_pc(rob_flush_pc)
   );

   always #5 clk = ~clk;

   int ncmp = 0, nfail = 0;
   int issued = 0, allow = 0, lat = 1, cyc = 0;
   logic bp_en = 0, err_en = 0;
   logic [31:0] bp_at = 0, bp_tgt = 0, err_at = 0;
   typedef struct {int due; logic [29:0] a;} pend_t;
   pend_t pend[$];
   logic [80:0] exp_q[$];

   function automatic logic [15:0] tag_of(input logic [31:0] a);
      return a[17:2] ^ 16'hA000;
   endfunction
   function automatic logic [80:0] mk(input logic err, input logic [31:0] a, input logic tk, input logic [15:0] tg);
      return {err, a[31:1], err ? 32'h0 : (a ^ 32'h1357_9BDF), tg, tk};
   endfunction

   assign ic_fetch_ready = issued < allow;
   assign bp_fetch_taken = bp_en && ({fetch_bp_addr, 2'b00} == bp_at);
   assign bp_fetch_target = bp_tgt[31:1];
   assign bp_fetch_tag = tag_of({fetch_bp_addr, 2'b00});

   // cache model: accepts on ready, answers in order after lat cycles
   always @(posedge clk) begin
      logic h;
      pend_t p;
      h = fetch_ic_req && ic_fetch_ready;
      if (h) pend.push_back('{cyc + lat - 1, fetch_ic_addr});
      #1;
      if (h) issued++;
      ic_fetch_valid = 0;
      ic_fetch_error = 0;
      ic_fetch_insn = 0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         p = pend.pop_front();
         ic_fetch_valid = 1;
         ic_fetch_error = err_en && ({p.a, 2'b00} == err_at);
         ic_fetch_insn = {p.a, 2'b00} ^ 32'h1357_9BDF;
      end
      cyc++;
   end

   // monitor: every head consumed by decode is checked against the scoreboard
   always @(negedge clk) begin
      logic [80:0] got, e;
      if (rst_n && fetch_de_valid && !decode_stall) begin
         got = {fetch_de_error, fetch_de_addr, fetch_de_insn, fetch_de_bptag, fetch_de_bptaken};
         ncmp++;
         if (exp_q.size() == 0) begin
            nfail++;
            $display("FAIL head_unexpected got=%h expected none", got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               nfail++;
               $display("FAIL head got=%h expected=%h", got, e);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      ncmp++;
      if (act !== req) begin
         nfail++;
         $display("FAIL %s got=%h expected=%h", nm, act, req);
      end
   endtask
   task automatic drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || fetch_de_valid || pend.size() != 0) && n < budget) begin
         step();
         n++;
      end
      check("drain_timeout", 32'(n >= budget), 0);
      repeat (5) step();
   endtask
   task automatic flush_to(input logic [31:0] a);
      rob_flush = 1;
      rob_flush_pc = a[31:1];
      step();
      rob_flush = 0;
   endtask

   initial begin
      int n, base;
      #3;
      check("rst_req", 32'(fetch_ic_req), 0);
      check("rst_valid", 32'(fetch_de_valid), 0);
      check("rst_addr", {fetch_ic_addr, 2'b00}, 0);
      // 1: sequential fetch from reset, first head on cycle 3
      for (int i = 0; i < 8; i++) exp_q.push_back(mk(0, 32'(i * 4), 0, tag_of(32'(i * 4))));
      allow = 8;
      @(posedge clk);
      #2 rst_n = 1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!fetch_de_valid && n < 20);
      check("first_valid_cycle", 32'(n), 3);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         if (fetch_de_valid) n++;
         @(negedge clk);
      end
      check("consecutive_valid", 32'(n), 8);
      drain(100);
      check("t1_issued", 32'(issued), 8);
      // 2: taken prediction at 0x8 redirects to 0x100
      bp_en = 1;
      bp_at = 32'h8;
      bp_tgt = 32'h100;
      exp_q.push_back(mk(0, 32'h0, 0, tag_of(32'h0)));
      exp_q.push_back(mk(0, 32'h4, 0, tag_of(32'h4)));
      exp_q.push_back(mk(0, 32'h8, 1, tag_of(32'h8)));
      exp_q.push_back(mk(0, 32'h100, 0, tag_of(32'h100)));
      exp_q.push_back(mk(0, 32'h104, 0, tag_of(32'h104)));
      flush_to(32'h0);
      allow = issued + 5;
      drain(100);
      bp_en = 0;
      // 3: stall caps acceptance at QDEPTH and holds the head
      base = issued;
      for (int i = 0; i < 8; i++) exp_q.push_back(mk(0, 32'h108 + 32'(i * 4), 0, tag_of(32'h108 + 32'(i * 4))));
      decode_stall = 1;
      allow = issued + 8;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (fetch_de_valid) check("stall_head", {fetch_de_addr, 1'b0}, 32'h108);
      end
      check("stall_accepted", 32'(issued - base), 4);
      step();
      decode_stall = 0;
      drain(100);
      // 4: flush with three requests in flight
      lat = 4;
      base = issued;
      allow = issued + 3;
      n = 0;
      while (issued < base + 3 && n < 50) begin
         step();
         n++;
      end
      check("t4_inflight3", 32'(issued - base), 3);
      for (int i = 0; i < 4; i++) exp_q.push_back(mk(0, 32'h200 + 32'(i * 4), 0, tag_of(32'h200 + 32'(i * 4))));
      allow = issued + 4;
      flush_to(32'h200);
      @(negedge clk);
      check("t4_empty_after_flush", 32'(fetch_de_valid), 0);
      drain(200);
      lat = 1;
      // 5: access fault at 0x40 halts fetch; the request already issued behind it still drains
      err_en = 1;
      err_at = 32'h40;
      base = issued;
      exp_q.push_back(mk(0, 32'h38, 0, tag_of(32'h38)));
      exp_q.push_back(mk(0, 32'h3C, 0, tag_of(32'h3C)));
      exp_q.push_back(mk(1, 32'h40, 0, tag_of(32'h40)));
      exp_q.push_back(mk(0, 32'h44, 0, tag_of(32'h44)));
      allow = issued + 8;
      flush_to(32'h38);
      drain(100);
      repeat (10) step();
      check("t5_halt_issued", 32'(issued - base), 4);
      err_en = 0;
      // 6: misaligned redirect yields one fault entry and no request
      base = issued;
      exp_q.push_back(mk(1, 32'h202, 0, 16'h0));
      flush_to(32'h202);
      drain(100);
      repeat (5) step();
      check("t6_no_request", 32'(issued - base), 0);
      // 7: asynchronous reset in the middle of a burst
      decode_stall = 1;
      allow = issued + 20;
      flush_to(32'h500);
      repeat (4) step();
      #4 rst_n = 0;
      pend.delete();
      #1;
      check("t7_req", 32'(fetch_ic_req), 0);
      check("t7_valid", 32'(fetch_de_valid), 0);
      check("t7_de_addr", {1'b0, fetch_de_addr}, 0);
      check("t7_ic_addr", {fetch_ic_addr, 2'b00}, 0);
      step();
      step();
      for (int i = 0; i < 4; i++) exp_q.push_back(mk(0, 32'(i * 4), 0, tag_of(32'(i * 4))));
      allow = issued + 4;
      decode_stall = 0;
      rst_n = 1;
      drain(100);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
